// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left, parallel load, frame-done pulse.
// Optional even-parity output enabled by defining PARITY_EN.
module univ_shift_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             si_r,
    input  logic             si_l,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
`ifdef PARITY_EN
    output logic             parity,
`endif
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             done_reg;
    logic             done_next;

    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    logic             shift_op;

    // Per-bit neighbour selection; the end bits take the serial inputs.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_vec[gi] = si_r;
            end else begin : g_mid_r
                assign shr_vec[gi] = q_reg[gi+1];
            end
            if (gi == 0) begin : g_lsb
                assign shl_vec[gi] = si_l;
            end else begin : g_mid_l
                assign shl_vec[gi] = q_reg[gi-1];
            end
        end
    endgenerate

    assign shift_op = en && ((mode == MODE_SHR) || (mode == MODE_SHL));

    always_comb begin
        q_next = q_reg;
        if (en) begin
            case (mode)
                MODE_SHR:  q_next = shr_vec;
                MODE_SHL:  q_next = shl_vec;
                MODE_LOAD: q_next = pi;
                default:   q_next = q_reg;
            endcase
        end
    end

    // Frame counter: a load restarts the frame, a direction change does not.
    always_comb begin
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        if (en && (mode == MODE_LOAD)) begin
            cnt_next = '0;
        end else if (shift_op) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next  = '0;
                done_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg    <= RESET_VAL;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            cnt_reg  <= cnt_next;
            done_reg <= done_next;
        end
    end

    assign q    = q_reg;
    assign so_r = q_reg[0];
    assign so_l = q_reg[WIDTH-1];
    assign done = done_reg;

`ifdef PARITY_EN
    assign parity = ^q_reg;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4): directed test-plan sequences plus random traffic
// checked every cycle against a behavioural model.
module tb_univ_shift_reg;

    localparam int W = 4;
    localparam logic [W-1:0] RV = '0;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         si_r;
    logic         si_l;
    logic [W-1:0] pi;
    logic [W-1:0] q;
    logic         so_r;
    logic         so_l;
    logic         done;
`ifdef PARITY_EN
    logic         parity;
`endif

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .si_r   (si_r),
        .si_l   (si_l),
        .pi     (pi),
        .q      (q),
        .so_r   (so_r),
        .so_l   (so_l),
`ifdef PARITY_EN
        .parity (parity),
`endif
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    // Model: register contents as a number, shifts counted since the last frame start.
    logic [W-1:0] m_q;
    int           m_shifts;
    logic         m_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                       input logic sr, input logic sl, input logic [W-1:0] p);
        rst = r; en = e; mode = m; si_r = sr; si_l = sl; pi = p;
        @(posedge clk);
        if (r) begin
            m_q = RV; m_shifts = 0; m_done = 1'b0;
        end else if (!e || m == 2'b00) begin
            m_done = 1'b0;
        end else if (m == 2'b11) begin
            m_q = p; m_shifts = 0; m_done = 1'b0;
        end else begin
            if (m == 2'b01) m_q = (m_q >> 1) | (W'(sr) << (W - 1));
            else            m_q = (m_q << 1) | W'(sl);
            m_shifts = m_shifts + 1;
            m_done = (m_shifts == W);
            if (m_done) m_shifts = 0;
        end
        #1;
        $display("cyc t=%0t rst=%0b en=%0b mode=%0b si_r=%0b si_l=%0b pi=%h -> q=%h done=%0b",
                 $time, r, e, m, sr, sl, p, q, done);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("q", 64'(q), 64'(m_q));
            chk("so_r", 64'(so_r), 64'(m_q % 2));
            chk("so_l", 64'(so_l), 64'(m_q / (2 ** (W - 1))));
            chk("done", 64'(done), 64'(m_done));
`ifdef PARITY_EN
            chk("parity", 64'(parity), 64'($countones(m_q) % 2));
`endif
        end
    end

    logic [3:0] sr_seq;
    logic [3:0] sol_seq;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; si_r = 1'b0; si_l = 1'b0; pi = '0;
        m_q = 'x; m_shifts = 0; m_done = 1'b0;

        // Reset then idle
        cyc(1, 0, 2'b00, 0, 0, 4'h0);
        checking = 1'b1;
        chk("lit_reset_q", 64'(q), 64'h0);
        chk("lit_reset_done", 64'(done), 64'h0);
        chk("lit_reset_so_r", 64'(so_r), 64'h0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 2'b00, 1, 1, 4'hF);
        chk("lit_hold_q", 64'(q), 64'h0);

        // SISO right: 1,1,0,0
        sr_seq = 4'b0011; // bit i is the value driven on shift i
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 2'b01, sr_seq[i], 0, 4'h0);
            if (i < 3) chk("lit_siso_nodone", 64'(done), 64'h0);
        end
        chk("lit_siso_q", 64'(q), 64'h3);
        chk("lit_siso_so_r", 64'(so_r), 64'h1);
        chk("lit_siso_done", 64'(done), 64'h1);
        cyc(0, 1, 2'b01, 0, 0, 4'h0);
        chk("lit_siso_done_drop", 64'(done), 64'h0);

        // PISO: load 1010 then shift left with si_l=0
        cyc(0, 1, 2'b11, 0, 0, 4'b1010);
        chk("lit_load_q", 64'(q), 64'hA);
        sol_seq = 4'b0101; // expected so_l before shifts 0..3 is 1,0,1,0
        for (int i = 0; i < 4; i++) begin
            chk("lit_piso_so_l", 64'(so_l), 64'(sol_seq[i]));
            cyc(0, 1, 2'b10, 0, 0, 4'h0);
        end
        chk("lit_piso_q", 64'(q), 64'h0);
        chk("lit_piso_done", 64'(done), 64'h1);

        // Enable hold mid-frame
        cyc(0, 1, 2'b01, 1, 0, 4'h0);
        cyc(0, 1, 2'b01, 0, 0, 4'h0);
        cyc(0, 0, 2'b01, 1, 1, 4'h0);
        cyc(0, 0, 2'b10, 1, 1, 4'h0);
        chk("lit_en_frozen_q", 64'(q), 64'h4);
        cyc(0, 1, 2'b01, 1, 0, 4'h0);
        chk("lit_en_nodone", 64'(done), 64'h0);
        cyc(0, 1, 2'b01, 1, 0, 4'h0);
        chk("lit_en_done", 64'(done), 64'h1);

        // Reset mid-frame restarts the count
        for (int i = 0; i < 3; i++) cyc(0, 1, 2'b01, 1, 0, 4'h0);
        cyc(1, 1, 2'b01, 1, 0, 4'h0);
        chk("lit_midrst_q", 64'(q), 64'(RV));
        for (int i = 0; i < 3; i++) cyc(0, 1, 2'b10, 1, 1, 4'h0);
        chk("lit_midrst_nodone", 64'(done), 64'h0);
        cyc(0, 1, 2'b10, 1, 1, 4'h0);
        chk("lit_midrst_done", 64'(done), 64'h1);

        // Load mid-frame restarts the count
        for (int i = 0; i < 3; i++) cyc(0, 1, 2'b01, 0, 0, 4'h0);
        cyc(0, 1, 2'b11, 0, 0, 4'b0110);
        chk("lit_midload_q", 64'(q), 64'h6);
        for (int i = 0; i < 3; i++) cyc(0, 1, 2'b01, 0, 0, 4'h0);
        chk("lit_midload_nodone", 64'(done), 64'h0);
        cyc(0, 1, 2'b01, 0, 0, 4'h0);
        chk("lit_midload_done", 64'(done), 64'h1);

`ifdef PARITY_EN
        cyc(0, 1, 2'b11, 0, 0, 4'b1011);
        chk("lit_parity_load", 64'(parity), 64'h1);
        cyc(0, 1, 2'b01, 0, 0, 4'h0);
        chk("lit_parity_shift_q", 64'(q), 64'h5);
        chk("lit_parity_shift", 64'(parity), 64'h0);
`endif

        // Back-to-back frames: done every W shifts, no gap
        cyc(0, 1, 2'b11, 0, 0, 4'h9);
        for (int i = 1; i <= 3 * W; i++) begin
            cyc(0, 1, (i % 3 == 0) ? 2'b10 : 2'b01, i[0], i[1], 4'h0);
            chk("lit_b2b_done", 64'(done), 64'((i % W) == 0));
        end

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), W'($urandom));
        end

        @(negedge clk);
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; next generation of the fixed 4-bit serial-in/serial-out register.
- Supports hold, shift right, shift left and parallel load, selected per cycle by a 2-bit mode.
- Provides both serial outputs and a parallel output, so one block covers SISO, SIPO, PISO and PIPO use.
- A shift counter pulses a frame-done flag after every WIDTH shifts. Used in serial link and deserialiser datapaths.

Parameters:
- WIDTH, 4, register length in bits; legal range 2..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- si_r  input  1  serial input entering the MSB on shift right.
- si_l  input  1  serial input entering the LSB on shift left.
- pi  input  WIDTH  parallel load data.
- q  output  WIDTH  registered register contents (parallel out).
- so_r  output  1  q[0]; serial out for shift right.
- so_l  output  1  q[WIDTH-1]; serial out for shift left.
- done  output  1  registered one-cycle pulse; the WIDTH-th shift since the last load or reset has completed.
- parity  output  1  even-parity bit of q; present only with PARITY_EN.

Behaviour:
- Reset:
  - rst=1 at an edge gives q=RESET_VAL, cnt=0, done=0.
  - rst has priority over en and mode.
  - Reset mid-shift discards partial frame progress.
- Hold: en=0 or mode=00 keeps q and cnt unchanged and forces done=0 on the next edge.
- Shift right (en=1, mode=01):
  - q <= {si_r, q[WIDTH-1:1]}.
  - The bit previously at q[0] is lost.
- Shift left (en=1, mode=10):
  - q <= {q[WIDTH-2:0], si_l}.
  - The bit previously at q[WIDTH-1] is lost.
- Parallel load (en=1, mode=11):
  - q <= pi, cnt <= 0, done <= 0.
  - Load takes effect in one cycle; q shows pi after that edge.
- Counter:
  - Internal cnt, width $clog2(WIDTH+1).
  - Each shift (either direction) increments cnt.
  - On the shift where cnt == WIDTH-1: cnt wraps to 0 and done <= 1 for exactly one cycle.
  - Otherwise done <= 0.
  - Direction changes mid-frame do not clear cnt.
- Serial latency:
  - A bit driven on si_r at edge k appears on so_r after edge k+WIDTH-1, i.e. WIDTH shifts from entry to falling out.
  - Same applies for si_l to so_l.
- Serial outputs are combinational from registered q; no extra pipeline stage.
- Inputs are sampled only at the rising edge. Stimulus changes between edges have no effect.
- Back-to-back frames: continuous shifting gives a done pulse every WIDTH enabled shift cycles with no gap cycle.
- A load on the cycle after done starts a new frame with cnt=0.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - Adds output port parity = ^q (XOR of all bits, combinational from q).
  - parity is 0 after reset when RESET_VAL=0.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, WIDTH=4: rst=1 for 1 edge -> q=4'b0000, done=0, so_r=0. Then rst=0, mode=00 for 3 edges -> q stays 0000.
- SISO right: en=1, mode=01, si_r sequence 1,1,0,0 over 4 edges -> q=0011. so_r shows 1 after edge 4. done=1 in the cycle after edge 4 only. Next shift -> done=0.
- PISO/PIPO: mode=11, pi=4'b1010, then mode=10 with si_l=0 for 4 edges -> so_l sequence 1,0,1,0 -> q=0000, done pulses after 4th shift.
- Enable/hold: during a shift-right frame, en=0 for 2 edges after 2 shifts -> q and cnt frozen. Resume 2 shifts -> done after the 4th enabled shift, not earlier.
- Reset/load mid-frame: after 3 shifts assert rst -> q=RESET_VAL, cnt=0; 4 further shifts are needed for done. Repeat using mode=11 instead of rst -> same counter restart, q=pi.
- PARITY_EN: load pi=4'b1011 -> parity=1. Shift right with si_r=0 -> q=0101 -> parity=0.
